// File: rtl/cgra_exec_ctrl.sv
// cgra_exec_ctrl: run-sequencing controller in front of the CGRA execution unit.
// Host writes a 352-bit configuration into a shadow register (11 x 32-bit words).
// An accepted go commits shadow + transfer counts, pulses start, waits for done
// (or an optional timeout) and reports completion. The committed configuration
// is frozen for the whole run and holds until the next accepted go.
//
// Optional feature macro: CGRA_EXEC_CTRL_CYCLE_COUNT_EN
//   defined   -> run_cycles counts RUN cycles (saturating at 0xFFFF_FFFF)
//   undefined -> no counter logic, run_cycles is tied to 0
//
// Handshake: go is a single-cycle request honoured only in IDLE; start is a
// one-cycle pulse; done is a level sampled only in RUN; finished is a one-cycle
// pulse. All outputs are registered. The FSM state is visible as state_q.
module cgra_exec_ctrl #(
    parameter int CONF_WIDTH     = 352,
    parameter int CONF_WORDS     = 11,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_wr_en,
    input  logic [3:0]            cfg_wr_addr,
    input  logic [31:0]           cfg_wr_data,
    input  logic                  go,
    input  logic [63:0]           num_data_in_i,
    input  logic [63:0]           num_data_out_i,
    input  logic [31:0]           num_cicles_to_store_i,
    input  logic                  done,
    output logic                  start,
    output logic [CONF_WIDTH-1:0] conf,
    output logic [63:0]           num_data_in,
    output logic [63:0]           num_data_out,
    output logic [31:0]           num_cicles_to_store,
    output logic                  busy,
    output logic                  finished,
    output logic                  timed_out,
    output logic                  cfg_err,
    output logic [31:0]           run_cycles
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_RUN    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [3:0]  LAST_ADDR   = 4'(CONF_WORDS - 1);
    localparam logic [31:0] TIMEOUT_VAL = 32'(TIMEOUT_CYCLES);

    state_t                state_q, state_d;
    logic [CONF_WIDTH-1:0] shadow_q, shadow_d;
    logic [CONF_WIDTH-1:0] conf_q, conf_d;
    logic [63:0]           num_data_in_q, num_data_in_d;
    logic [63:0]           num_data_out_q, num_data_out_d;
    logic [31:0]           num_cicles_to_store_q, num_cicles_to_store_d;
    logic                  start_q, start_d;
    logic                  busy_q, busy_d;
    logic                  finished_q, finished_d;
    logic                  timed_out_q, timed_out_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [31:0]           tmo_cnt_q, tmo_cnt_d;
    logic                  go_accept;

    assign go_accept = (state_q == S_IDLE) && go;

    // Next-state logic, commit of configuration/counts, timeout detection and
    // the registered start/busy/finished outputs derived from the next state.
    always_comb begin
        state_d               = state_q;
        conf_d                = conf_q;
        num_data_in_d         = num_data_in_q;
        num_data_out_d        = num_data_out_q;
        num_cicles_to_store_d = num_cicles_to_store_q;
        timed_out_d           = timed_out_q;
        tmo_cnt_d             = tmo_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d               = S_START;
                    conf_d                = shadow_q;
                    num_data_in_d         = num_data_in_i;
                    num_data_out_d        = num_data_out_i;
                    num_cicles_to_store_d = num_cicles_to_store_i;
                    timed_out_d           = 1'b0;
                    tmo_cnt_d             = '0;
                end
            end
            S_START: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                // tmo_cnt_q + 1 is the number of the RUN cycle being sampled now.
                tmo_cnt_d = tmo_cnt_q + 32'd1;
                if (done) begin
                    state_d = S_FINISH;
                end else if ((TIMEOUT_VAL != 32'd0) &&
                             ((tmo_cnt_q + 32'd1) == TIMEOUT_VAL)) begin
                    timed_out_d = 1'b1;
                    state_d     = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        start_d    = (state_d == S_START);
        busy_d     = (state_d != S_IDLE);
        finished_d = (state_d == S_FINISH);
    end

    // Shadow writes and the sticky write-error flag; a write that lands together
    // with go updates the shadow only, since conf_d already took the old shadow.
    always_comb begin
        shadow_d  = shadow_q;
        cfg_err_d = cfg_err_q;
        if (go_accept) begin
            cfg_err_d = 1'b0;
        end
        if (cfg_wr_en) begin
            if ((state_q == S_IDLE) && (cfg_wr_addr <= LAST_ADDR)) begin
                for (int i = 0; i < CONF_WORDS; i++) begin
                    if (cfg_wr_addr == 4'(i)) begin
                        shadow_d[32*i +: 32] = cfg_wr_data;
                    end
                end
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q               <= S_IDLE;
            shadow_q              <= '0;
            conf_q                <= '0;
            num_data_in_q         <= '0;
            num_data_out_q        <= '0;
            num_cicles_to_store_q <= '0;
            start_q               <= 1'b0;
            busy_q                <= 1'b0;
            finished_q            <= 1'b0;
            timed_out_q           <= 1'b0;
            cfg_err_q             <= 1'b0;
            tmo_cnt_q             <= '0;
        end else begin
            state_q               <= state_d;
            shadow_q              <= shadow_d;
            conf_q                <= conf_d;
            num_data_in_q         <= num_data_in_d;
            num_data_out_q        <= num_data_out_d;
            num_cicles_to_store_q <= num_cicles_to_store_d;
            start_q               <= start_d;
            busy_q                <= busy_d;
            finished_q            <= finished_d;
            timed_out_q           <= timed_out_d;
            cfg_err_q             <= cfg_err_d;
            tmo_cnt_q             <= tmo_cnt_d;
        end
    end

`ifdef CGRA_EXEC_CTRL_CYCLE_COUNT_EN
    logic [31:0] run_cycles_q, run_cycles_d;

    // Saturating RUN-cycle counter, cleared on an accepted go.
    always_comb begin
        run_cycles_d = run_cycles_q;
        if (go_accept) begin
            run_cycles_d = '0;
        end else if ((state_q == S_RUN) && (run_cycles_q != 32'hFFFF_FFFF)) begin
            run_cycles_d = run_cycles_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cycles_q <= '0;
        end else begin
            run_cycles_q <= run_cycles_d;
        end
    end

    assign run_cycles = run_cycles_q;
`else
    assign run_cycles = '0;
`endif

    assign start               = start_q;
    assign conf                = conf_q;
    assign num_data_in         = num_data_in_q;
    assign num_data_out        = num_data_out_q;
    assign num_cicles_to_store = num_cicles_to_store_q;
    assign busy                = busy_q;
    assign finished            = finished_q;
    assign timed_out           = timed_out_q;
    assign cfg_err             = cfg_err_q;

endmodule

// File: tb/tb_cgra_exec_ctrl.sv
// Testbench for cgra_exec_ctrl. The reference model keeps the shadow as an
// array of words and predicts each run from its plan: the RUN cycle at which
// done is first seen, the timeout limit, and the resulting end cycle.
module tb_cgra_exec_ctrl;

    localparam int TMO = 24;

    logic         clk;
    logic         rst;
    logic         cfg_wr_en;
    logic [3:0]   cfg_wr_addr;
    logic [31:0]  cfg_wr_data;
    logic         go;
    logic [63:0]  num_data_in_i;
    logic [63:0]  num_data_out_i;
    logic [31:0]  num_cicles_to_store_i;
    logic         done;
    logic         start;
    logic [351:0] conf;
    logic [63:0]  num_data_in;
    logic [63:0]  num_data_out;
    logic [31:0]  num_cicles_to_store;
    logic         busy;
    logic         finished;
    logic         timed_out;
    logic         cfg_err;
    logic [31:0]  run_cycles;

    cgra_exec_ctrl #(
        .CONF_WIDTH    (352),
        .CONF_WORDS    (11),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .cfg_wr_en            (cfg_wr_en),
        .cfg_wr_addr          (cfg_wr_addr),
        .cfg_wr_data          (cfg_wr_data),
        .go                   (go),
        .num_data_in_i        (num_data_in_i),
        .num_data_out_i       (num_data_out_i),
        .num_cicles_to_store_i(num_cicles_to_store_i),
        .done                 (done),
        .start                (start),
        .conf                 (conf),
        .num_data_in          (num_data_in),
        .num_data_out         (num_data_out),
        .num_cicles_to_store  (num_cicles_to_store),
        .busy                 (busy),
        .finished             (finished),
        .timed_out            (timed_out),
        .cfg_err              (cfg_err),
        .run_cycles           (run_cycles)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and reference model state
    int           n_cmp;
    int           n_err;
    logic [351:0] exp_q[$];
    logic [31:0]  m_shadow[11];
    logic [351:0] m_conf;
    logic [63:0]  m_nin;
    logic [63:0]  m_nout;
    logic [31:0]  m_ncs;
    logic         m_err;
    logic         m_tmo;
    logic [31:0]  m_rc;

    task automatic check(input string tag, input logic [351:0] act, input logic [351:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [351:0] pack_shadow();
        logic [351:0] r;
        for (int i = 0; i < 11; i++) r[32*i +: 32] = m_shadow[i];
        return r;
    endfunction

    function automatic logic [31:0] rc_exp(input int k);
`ifdef CGRA_EXEC_CTRL_CYCLE_COUNT_EN
        return 32'(k);
`else
        return 32'd0;
`endif
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 11; i++) m_shadow[i] = '0;
        m_conf = '0; m_nin = '0; m_nout = '0; m_ncs = '0;
        m_err = 1'b0; m_tmo = 1'b0; m_rc = '0;
    endtask

    task automatic check_held(input string tag);
        check({tag, "_conf"}, conf, m_conf);
        check({tag, "_nin"}, num_data_in, m_nin);
        check({tag, "_nout"}, num_data_out, m_nout);
        check({tag, "_ncs"}, num_cicles_to_store, m_ncs);
        check({tag, "_cfg_err"}, cfg_err, m_err);
        check({tag, "_timed_out"}, timed_out, m_tmo);
        check({tag, "_run_cycles"}, run_cycles, m_rc);
    endtask

    // Driver: one shadow write while idle.
    task automatic idle_write(input logic [3:0] a, input logic [31:0] d);
        cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
        step();
        cfg_wr_en = 1'b0;
        if (a <= 4'd10) m_shadow[a] = d;
        else m_err = 1'b1;
        check("idle_wr_cfg_err", cfg_err, m_err);
        check("idle_wr_busy", busy, 1'b0);
        check("idle_wr_conf", conf, m_conf);
    endtask

    // Driver: one full run. d_at is the RUN cycle at which done is first seen
    // (0 = never). wr_go writes a word with go, wr_run writes during RUN,
    // go_spam holds go high throughout the busy period.
    task automatic run_one(input int d_at, input bit wr_go, input bit wr_run, input bit go_spam);
        int          e;
        logic [3:0]  a;
        logic [31:0] wd;
        e = (d_at != 0 && d_at <= TMO) ? d_at : TMO;
        a = 4'($urandom_range(0, 10));
        wd = $urandom;
        num_data_in_i = {$urandom, $urandom};
        num_data_out_i = {$urandom, $urandom};
        num_cicles_to_store_i = $urandom;
        go = 1'b1;
        exp_q.push_back(pack_shadow());
        if (wr_go) begin
            cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = wd;
        end
        step();
        go = 1'b0; cfg_wr_en = 1'b0;
        if (wr_go) m_shadow[a] = wd;
        m_conf = exp_q.pop_front();
        m_nin = num_data_in_i; m_nout = num_data_out_i; m_ncs = num_cicles_to_store_i;
        m_err = 1'b0; m_tmo = 1'b0; m_rc = '0;
        check("go_start", start, 1'b1);
        check("go_busy", busy, 1'b1);
        check("go_finished", finished, 1'b0);
        check_held("go");
        num_data_in_i = {$urandom, $urandom};
        go = go_spam;
        step();
        check("run0_start", start, 1'b0);
        check("run0_busy", busy, 1'b1);
        for (int k = 1; k <= TMO + 1; k++) begin
            done = (d_at != 0 && k >= d_at);
            go = go_spam;
            if (wr_run && k == 1) begin
                cfg_wr_en = 1'b1; cfg_wr_addr = 4'($urandom_range(0, 15)); cfg_wr_data = 32'hDEAD_BEEF;
                m_err = 1'b1;
            end
            step();
            cfg_wr_en = 1'b0;
            m_rc = rc_exp(k);
            check("run_start", start, 1'b0);
            check("run_busy", busy, 1'b1);
            if (k == e) begin
                m_tmo = (d_at == 0 || d_at > TMO);
                check("end_finished", finished, 1'b1);
                check_held("end");
                break;
            end
            check("run_finished", finished, 1'b0);
            check_held("run");
        end
        done = 1'b0;
        go = go_spam;
        step();
        go = 1'b0;
        check("post_busy", busy, 1'b0);
        check("post_finished", finished, 1'b0);
        check("post_start", start, 1'b0);
        check_held("post");
    endtask

    // Driver: reset pulsed in the middle of a run.
    task automatic mid_run_reset();
        go = 1'b1;
        num_data_in_i = {$urandom, $urandom};
        step();
        go = 1'b0;
        repeat (4) step();
        check("mrr_busy_before", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_model();
        check("mrr_busy", busy, 1'b0);
        check("mrr_finished", finished, 1'b0);
        check("mrr_start", start, 1'b0);
        check_held("mrr");
        step();
        check("mrr_finished_next", finished, 1'b0);
        check("mrr_busy_next", busy, 1'b0);
    endtask

    initial begin
        int nw;
        n_cmp = 0; n_err = 0;
        rst = 1'b1; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0; go = 1'b0;
        num_data_in_i = '0; num_data_out_i = '0; num_cicles_to_store_i = '0; done = 1'b0;
        clear_model();
        step(); step();
        rst = 1'b0;
        check("rst_start", start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_finished", finished, 1'b0);
        check_held("rst");

        // Basic run
        for (int i = 0; i < 11; i++) idle_write(4'(i), 32'h1000_0000 + 32'(i));
        run_one(20, 1'b0, 1'b0, 1'b0);
        check("basic_conf_lo", conf[31:0], 32'h1000_0000);
        check("basic_conf_hi", conf[351:320], 32'h1000_000A);

        // Out-of-range addresses
        idle_write(4'd11, 32'h1234_5678);
        idle_write(4'd15, 32'h0BAD_0BAD);

        // Timeout, done coinciding with timeout, done one cycle late, done at cycle 1
        run_one(0, 1'b0, 1'b0, 1'b0);
        run_one(TMO, 1'b0, 1'b0, 1'b0);
        run_one(TMO + 1, 1'b0, 1'b0, 1'b0);
        run_one(1, 1'b0, 1'b0, 1'b0);

        // Write during run, then a run that commits the old contents
        run_one(10, 1'b0, 1'b1, 1'b0);
        run_one(3, 1'b0, 1'b0, 1'b0);

        // Same-cycle write and go, then a run that commits the new word
        run_one(5, 1'b1, 1'b0, 1'b0);
        run_one(4, 1'b0, 1'b0, 1'b0);

        // go held high while busy
        run_one(7, 1'b0, 1'b0, 1'b1);

        mid_run_reset();
        run_one(2, 1'b0, 1'b0, 1'b0);

        // Random runs
        for (int r = 0; r < 15; r++) begin
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) idle_write(4'($urandom_range(0, 11)), $urandom);
            run_one($urandom_range(0, TMO + 4), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cgra_exec_ctrl.md
# cgra_exec_ctrl

Run-sequencing controller placed in front of the CGRA execution unit (16 PEs plus the 32x32 crossbar). Host logic writes a 352-bit configuration into a shadow register in 32-bit words. The block then commits that configuration together with the transfer counts, pulses `start`, waits for `done`, and reports completion or timeout. The committed configuration stays frozen for the whole run, so host writes never disturb a running array.

## Interface
Parameters:
- `CONF_WIDTH`, 352, total configuration width. Per PE: 8-bit opcode field plus 10-bit crossbar select, on a 22-bit stride.
- `CONF_WORDS`, 11, number of 32-bit shadow words (`CONF_WIDTH`/32).
- `TIMEOUT_CYCLES`, 0, maximum RUN cycles before abort. 0 disables the timeout.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `cfg_wr_en` in 1: shadow word write strobe.
- `cfg_wr_addr` in 4: shadow word index, 0..10.
- `cfg_wr_data` in 32: data for the addressed word; word i maps to bits [32i+31:32i].
- `go` in 1: single-cycle run request.
- `num_data_in_i` in 64: input transfer count, sampled on accepted `go`.
- `num_data_out_i` in 64: output transfer count, sampled on accepted `go`.
- `num_cicles_to_store_i` in 32: store delay, sampled on accepted `go`.
- `done` in 1: completion level from the execution unit.
- `start` out 1: run start pulse to the execution unit.
- `conf` out 352: committed configuration.
- `num_data_in` out 64: committed input transfer count.
- `num_data_out` out 64: committed output transfer count.
- `num_cicles_to_store` out 32: committed store delay.
- `busy` out 1: high whenever state is not IDLE.
- `finished` out 1: one-cycle pulse at the end of a run.
- `timed_out` out 1: sticky flag, cleared on the next accepted `go`.
- `cfg_err` out 1: sticky flag for a rejected write, cleared on the next accepted `go`.
- `run_cycles` out 32: RUN-state cycle count.

## Operation
States: IDLE, START, RUN, FINISH.

- **IDLE**
  - `cfg_wr_en` with `cfg_wr_addr` < 11 updates that shadow word.
  - `cfg_wr_en` with address ≥ 11 is dropped and sets `cfg_err`.
  - `go`=1:
    - Copy shadow to `conf`.
    - Latch the three count inputs into their committed outputs.
    - Clear `timed_out`, `cfg_err` and `run_cycles`.
    - Go to START.
- **START**: `start`=1 for exactly this one cycle. Go to RUN. `done` is ignored here.
- **RUN**
  - `done`=1: go to FINISH.
  - Otherwise, if `TIMEOUT_CYCLES`≠0 and this is RUN cycle number `TIMEOUT_CYCLES`: set `timed_out` and go to FINISH.
  - If `done` and the timeout occur in the same cycle, `done` wins and `timed_out` stays 0.
- **FINISH**: `finished`=1 for this one cycle. Go to IDLE.

Boundary rules:
- `cfg_wr_en` outside IDLE is dropped and sets `cfg_err`.
- `go` outside IDLE is ignored, with no flag.
- `cfg_wr_en` and `go` in the same IDLE cycle:
  - The write lands in the shadow register.
  - `conf` receives the shadow contents from before that write.
- `conf` and the committed counts change only on an accepted `go`. They hold after FINISH until the next accepted `go`.
- The execution unit must drop `done` within one cycle of `start`. `done` is therefore sampled only in RUN.
- `rst` asserted mid-run forces the reset values on the next edge, and the state machine returns to IDLE. The execution unit shares `rst`.

## Timing
- Reset values: state IDLE; shadow, `conf` and committed counts 0; `start`, `busy`, `finished`, `timed_out`, `cfg_err` 0; `run_cycles` 0.
- All outputs are registered.
- `go` sampled at edge N:
  - `conf`, the counts, `start` and `busy` are valid from edge N (the cycle after `go`).
  - RUN begins at edge N+1.
- `done` sampled at edge M in RUN: `finished` is high for the cycle following edge M; IDLE from edge M+1.
- Minimum go-to-go spacing is 4 cycles.
- `run_cycles`:
  - Increments once per RUN cycle, including the exit cycle.
  - Saturates at 0xFFFF_FFFF; no wrap.

## Configuration
- `CGRA_EXEC_CTRL_CYCLE_COUNT_EN`
  - Defined: the `run_cycles` counter is implemented as described.
  - Undefined: no counter logic; `run_cycles` is tied to 0. The port list is unchanged.
- All other behaviour is identical with or without the macro.

## Test plan
- **Basic run.** Write words 0..10 with 0x1000_0000+i, then `go` with counts 8/4/3; `done` rises 20 cycles after `start`.
  - `conf`[31:0]=0x1000_0000 and `conf`[351:320]=0x1000_000A.
  - One `start` pulse, one `finished` pulse.
  - `run_cycles`=20 with the macro, 0 without.
- **Timeout.** `TIMEOUT_CYCLES`=16 and `done` held 0.
  - `timed_out`=1 and `finished` pulses 18 cycles after `go`.
  - `busy` is 0 the cycle after.
- **Write during run.** Write word 2=0xDEAD_BEEF in RUN.
  - `conf` is unchanged and `cfg_err`=1.
  - The next `go` clears `cfg_err` and commits the old word 2.
- **Same-cycle write and go.**
  - `conf` takes the pre-write word.
  - A second `go` commits the new word.
- **Mid-run reset.** `rst` pulsed in RUN.
  - Next cycle: `conf`=0, `busy`=0, and no `finished` pulse.
- **Edge cases.**
  - `go` while busy is ignored: exactly one `start` per run.
  - Address 11 write sets `cfg_err`.
  - `done` in the same cycle as the timeout gives `timed_out`=0.
